// File: rtl/byte_packer_pkg.sv
// Shared sizing for the byte packer: default geometry, derived word width,
// lane-counter width and the saturation limit of the word counter.
package byte_packer_pkg;

  localparam int BP_BYTES  = 4;
  localparam int BP_DW_IN  = 8;
  localparam int BP_DW_OUT = BP_BYTES * BP_DW_IN;
  localparam int BP_CNT_W  = $clog2(BP_BYTES);

  localparam logic [15:0] WORD_CNT_MAX = 16'hFFFF;

  // Lane-counter width for an arbitrary geometry; never narrower than one bit.
  function automatic int lane_cnt_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/byte_packer_if.sv
// Valid/ready bundle around byte_packer: byte stream in, packed word stream out.
// master = the side feeding bytes and consuming words; slave = the packer.
interface byte_packer_if
  import byte_packer_pkg::*;
#(
  parameter int BYTES = BP_BYTES,
  parameter int DW_IN = BP_DW_IN
);

  logic [DW_IN-1:0]       in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [BYTES*DW_IN-1:0] out_data;
  logic [BYTES-1:0]       out_keep;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [15:0]            word_cnt;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid, word_cnt
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid, word_cnt
  );

endinterface

// File: rtl/byte_packer.sv
// Packs a valid/ready byte stream little-endian into BYTES-wide words with a
// keep mask and packet-end flag; one output register, latency of one cycle.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int BYTES = BP_BYTES,
  parameter int DW_IN = BP_DW_IN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW_IN-1:0]       in_data_i,
  input  logic                   in_valid_i,
  input  logic                   in_last_i,
  output logic                   in_ready_o,
  output logic [BYTES*DW_IN-1:0] out_data_o,
  output logic [BYTES-1:0]       out_keep_o,
  output logic                   out_last_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [15:0]            word_cnt_o
);

  localparam int DW_OUT = BYTES * DW_IN;
  localparam int CNT_W  = lane_cnt_w(BYTES);

  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [DW_OUT-1:0] acc_q,       acc_d;
  logic [DW_OUT-1:0] out_data_q,  out_data_d;
  logic [BYTES-1:0]  out_keep_q,  out_keep_d;
  logic              out_last_q,  out_last_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       word_cnt_q,  word_cnt_d;

  logic              in_hs_s;
  logic              out_hs_s;
  logic              complete_s;
  logic [DW_OUT-1:0] merged_s;
  logic [BYTES-1:0]  keep_s;

  assign in_ready_o  = !out_valid_q | out_ready_i;
  assign in_hs_s     = in_valid_i & in_ready_o;
  assign out_hs_s    = out_valid_q & out_ready_i;
  assign complete_s  = in_hs_s & ((cnt_q == CNT_W'(BYTES - 1)) | in_last_i);

  assign out_data_o  = out_data_q;
  assign out_keep_o  = out_keep_q;
  assign out_last_o  = out_last_q;
  assign out_valid_o = out_valid_q;
  assign word_cnt_o  = word_cnt_q;

  // Accumulator with the incoming byte dropped into lane cnt, plus its keep mask.
  always_comb begin
    merged_s = acc_q;
    keep_s   = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        merged_s[k*DW_IN +: DW_IN] = in_data_i;
      end else begin
        merged_s[k*DW_IN +: DW_IN] = acc_q[k*DW_IN +: DW_IN];
      end
      keep_s[k] = (CNT_W'(k) <= cnt_q) ? 1'b1 : 1'b0;
    end
  end

  // Next-state for lane counter, accumulator, output register and word counter.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    word_cnt_d  = word_cnt_q;

    if (complete_s) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (in_hs_s) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = merged_s;
    end else begin
      cnt_d = cnt_q;
      acc_d = acc_q;
    end

    // A fresh word wins over a drain, so valid stays high across load+drain.
    if (complete_s) begin
      out_data_d  = merged_s;
      out_keep_d  = keep_s;
      out_last_d  = in_last_i;
      out_valid_d = 1'b1;
    end else if (out_hs_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (out_hs_s && (word_cnt_q != WORD_CNT_MAX)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // State registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= 16'd0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: a byte-queue reference model checked
// every cycle, directed scenarios pinned with literal words, then random traffic.
module tb_byte_packer;
  import byte_packer_pkg::*;

  localparam int NB = BP_BYTES;
  localparam int DI = BP_DW_IN;
  localparam int DO = BP_DW_OUT;

  logic clk;
  logic rst_n;

  byte_packer_if #(.BYTES(NB), .DW_IN(DI)) bus ();

  byte_packer #(.BYTES(NB), .DW_IN(DI)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (bus.in_data),
    .in_valid_i  (bus.in_valid),
    .in_last_i   (bus.in_last),
    .in_ready_o  (bus.in_ready),
    .out_data_o  (bus.out_data),
    .out_keep_o  (bus.out_keep),
    .out_last_o  (bus.out_last),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .word_cnt_o  (bus.word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, got, exp, $time);
  endtask

  // Reference model: bytes of the open word in a queue, one pending output word.
  logic [DI-1:0] cur[$];
  logic          m_valid;
  logic [DO-1:0] m_data;
  logic [NB-1:0] m_keep;
  logic          m_last;
  logic [15:0]   m_wcnt;

  initial begin
    logic rdy;
    logic ohs;
    m_valid = 1'b0; m_data = '0; m_keep = '0; m_last = 1'b0; m_wcnt = 16'd0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_valid = 1'b0; m_data = '0; m_keep = '0; m_last = 1'b0; m_wcnt = 16'd0;
        cur.delete();
      end else begin
        rdy = !m_valid || bus.out_ready;
        ohs = m_valid && bus.out_ready;
        if (ohs && m_wcnt != 16'hFFFF) m_wcnt = m_wcnt + 16'd1;
        if (ohs) m_valid = 1'b0;
        if (bus.in_valid && rdy) begin
          cur.push_back(bus.in_data);
          if (cur.size() == NB || bus.in_last) begin
            m_data = '0;
            foreach (cur[i]) m_data = m_data | (DO'(cur[i]) << (DI * i));
            m_keep = NB'((1 << cur.size()) - 1);
            m_last = bus.in_last;
            m_valid = 1'b1;
            cur.delete();
          end
        end
      end
    end
  end

  // Words actually handed downstream, as {last, keep, data}.
  logic [63:0] got[$];

  // Per-cycle comparison against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("in_ready", 64'(bus.in_ready), 64'(!m_valid || bus.out_ready));
      chk("word_cnt", 64'(bus.word_cnt), 64'(m_wcnt));
      if (m_valid) begin
        chk("out_data", 64'(bus.out_data), 64'(m_data));
        chk("out_keep", 64'(bus.out_keep), 64'(m_keep));
        chk("out_last", 64'(bus.out_last), 64'(m_last));
      end
      if (bus.out_valid && bus.out_ready)
        got.push_back({27'd0, bus.out_last, bus.out_keep, bus.out_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted; afterwards park junk on the bus.
  task automatic send(input logic [7:0] b, input logic l);
    int n;
    logic r;
    bus.in_valid = 1'b1; bus.in_data = b; bus.in_last = l;
    n = 0;
    do begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      n++;
    end while (!r && n < 50);
    if (!r) chk("send_timeout", 64'd0, 64'd1);
    #1;
    bus.in_valid = 1'b0; bus.in_data = 8'hEE; bus.in_last = 1'b1;
  endtask

  function automatic logic [63:0] wd(input logic l, input logic [3:0] k, input logic [31:0] d);
    return {27'd0, l, k, d};
  endfunction

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_keep", 64'(bus.out_keep), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_wcnt", 64'(bus.word_cnt), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    step();
    rst_n = 1'b1;

    // Full word, back-to-back, downstream always ready.
    bus.out_ready = 1'b1;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    @(negedge clk);
    chk("w1_valid", 64'(bus.out_valid), 64'd1);
    chk("w1_data", 64'(bus.out_data), 64'h44332211);
    chk("w1_keep", 64'(bus.out_keep), 64'hF);
    chk("w1_last", 64'(bus.out_last), 64'd0);
    step();
    @(negedge clk);
    chk("w1_wcnt", 64'(bus.word_cnt), 64'd1);

    // Short packet.
    step();
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    @(negedge clk);
    chk("w2_data", 64'(bus.out_data), 64'h0000BBAA);
    chk("w2_keep", 64'(bus.out_keep), 64'h3);
    chk("w2_last", 64'(bus.out_last), 64'd1);
    step();

    // Backpressure: word held, next byte stalls, then both move together.
    bus.out_ready = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_data", 64'(bus.out_data), 64'h04030201);
      chk("bp_keep", 64'(bus.out_keep), 64'hF);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next", wd(bus.out_last, bus.out_keep, bus.out_data), wd(1'b1, 4'h1, 32'h00000055));
    step();

    // Continuous 8-byte stream.
    got.delete();
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    step(); step();
    chk("s8_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("s8_w0", got[0], wd(1'b0, 4'hF, 32'h04030201));
      chk("s8_w1", got[1], wd(1'b0, 4'hF, 32'h08070605));
    end

    // Reset mid-packet drops the partial word.
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    rst_n = 1'b0;
    step(); step();
    chk("mr_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    got.delete();
    send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0); send(8'h08, 1'b0);
    step(); step();
    chk("mr_count", 64'(got.size()), 64'd1);
    if (got.size() == 1) chk("mr_w0", got[0], wd(1'b0, 4'hF, 32'h08070605));

    // Random traffic with backpressure, gaps and random packet ends.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.in_last   = ($urandom_range(0, 5) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step(); step();

    // Word counter saturation using single-byte packets every cycle.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    got.delete();
    for (int i = 0; i < 65534; i++) send(8'($urandom), 1'b1);
    step(); step();
    got.delete();
    chk("sat_fffe", 64'(bus.word_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1);
    step(); step();
    chk("sat_ffff", 64'(bus.word_cnt), 64'hFFFF);
    chk("sat_words", 64'(got.size()), 64'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 SHALL have parameter BYTES, default 4, meaning bytes per output word (legal 2..8).
REQ-002 SHALL have parameter DW_IN, default 8, meaning input byte width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data_i  input  DW_IN  byte from the upstream valid/ready stage.
REQ-006 SHALL have port in_valid_i  input  1  upstream byte valid.
REQ-007 SHALL have port in_last_i  input  1  byte is the final byte of a packet; qualified by in_valid_i.
REQ-008 SHALL have port in_ready_o  output  1  packer can accept a byte.
REQ-009 SHALL have port out_data_o  output  BYTES*DW_IN  packed word.
REQ-010 SHALL have port out_keep_o  output  BYTES  per-byte valid mask of out_data_o.
REQ-011 SHALL have port out_last_o  output  1  word ends a packet.
REQ-012 SHALL have port out_valid_o  output  1  word valid to downstream.
REQ-013 SHALL have port out_ready_i  input  1  downstream accepts word.
REQ-014 SHALL have port word_cnt_o  output  16  count of output handshakes, saturating.

Function
REQ-015 SHALL define an input handshake as in_valid_i & in_ready_o, and an output handshake as out_valid_o & out_ready_i, both sampled at the rising clock edge.
REQ-016 SHALL drive in_ready_o = !out_valid_o | out_ready_i, combinationally, with no dependence on in_valid_i or in_last_i.
REQ-017 SHALL pack bytes little-endian: the first byte of a word goes to bits [DW_IN-1:0], and byte k goes to lane k.
REQ-018 SHALL keep a lane counter cnt (0..BYTES-1) that increments on each input handshake.
REQ-019 SHALL treat a byte as completing the word when cnt==BYTES-1 or in_last_i=1; on that handshake the word SHALL be loaded into the output register, cnt SHALL return to 0, and the accumulator SHALL clear.
REQ-020 SHALL assert out_valid_o in the cycle after the completing handshake (latency 1); a word completion with a simultaneous output handshake SHALL keep out_valid_o=1 and present the new word.
REQ-021 SHALL deassert out_valid_o after an output handshake when no completion happens in the same cycle.
REQ-022 SHALL hold out_data_o, out_keep_o and out_last_o stable while out_valid_o=1 and out_ready_i=0.
REQ-023 SHALL set out_keep_o bits [cnt:0] for the completing byte and zero the upper bits; out_data_o lanes with keep=0 SHALL be 0.
REQ-024 SHALL set out_last_o equal to in_last_i of the completing byte.
REQ-025 SHALL produce keep=1 (only bit 0 set) and last=1 when in_last_i=1 arrives on the first byte (cnt=0).
REQ-026 SHALL ignore in_data_i and in_last_i when no input handshake occurs.
REQ-027 SHALL increment word_cnt_o on each output handshake, saturating at 16'hFFFF with no wrap.

Reset
REQ-028 SHALL, while rst_n=0, set out_valid_o=0, out_data_o=0, out_keep_o=0, out_last_o=0, word_cnt_o=0, cnt=0 and clear the accumulator; a reset mid-packet SHALL discard the partial word.
REQ-029 SHALL have in_ready_o=1 during and after reset, since out_valid_o=0.

Structure
REQ-030 SHALL place the BYTES and DW_IN defaults, the derived DW_OUT=BYTES*DW_IN and the lane-counter width $clog2(BYTES) in the package byte_packer_pkg.
REQ-031 SHALL be implemented as a single module with no sub-module: accumulator, counter and output register are all local.

Verification
REQ-032 SHALL cover: bytes 11,22,33,44 back-to-back with out_ready_i=1 -> one cycle later out_data_o=32'h44332211, keep=4'hF, last=0, word_cnt_o=1.
REQ-033 SHALL cover: bytes AA,BB with in_last_i on BB -> out_data_o=32'h0000BBAA, keep=4'h3, last=1.
REQ-034 SHALL cover: word pending with out_ready_i=0 for 5 cycles -> in_ready_o=0, outputs stable, no byte lost; then out_ready_i=1 -> handshake, in_ready_o=1.
REQ-035 SHALL cover: a continuous 8-byte stream 01..08 with out_ready_i=1 -> words 32'h04030201 then 32'h08070605, with out_valid_o held across the simultaneous load/drain.
REQ-036 SHALL cover: rst_n pulsed low after bytes 01,02 -> no output word, then bytes 05,06,07,08 -> 32'h08070605.
REQ-037 SHALL cover: word_cnt_o forced near 16'hFFFE followed by 3 words -> word_cnt_o holds at 16'hFFFF.
